// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: owns the PC, fetches from imem, hands words to decode.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  WAIT_MAX = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        upd_valid,
  input  logic [1:0]  orig_pc,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  output logic [31:0] instret,
  output logic        fetch_fault
);

  localparam logic [1:0]  OrigPc4   = 2'b00;
  localparam logic [1:0]  OrigPcBeq = 2'b01;
  localparam logic [1:0]  OrigPcImm = 2'b10;
  localparam logic [31:0] Nop       = 32'h0000_0013;

  typedef enum logic [1:0] {StFetch, StWait, StIssue, StExec} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] instret_q, instret_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] pc_offset;
  logic [31:0] next_pc;
  logic        retire;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    pc_offset = 32'd4;
    case (orig_pc)
      OrigPcImm: pc_offset = imm;
      OrigPcBeq: pc_offset = branch_taken ? imm : 32'd4;
      OrigPc4:   pc_offset = 32'd4;
      default:   pc_offset = 32'd4;
    endcase
  end

  assign next_pc = pc_q + pc_offset;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    instret_d      = instret_q;
    wait_cnt_d     = wait_cnt_q;
    retire         = 1'b0;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d        = fault_q;
`endif

    unique case (state_q)
      StFetch: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d    = StWait;
          wait_cnt_d = 8'd0;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          instr_d    = imem_resp_data;
          instr_pc_d = pc_q;
          state_d    = StIssue;
        end else if (wait_cnt_q + 8'd1 == WAIT_MAX) begin
          // Response presumed lost: re-request the same pc.
          state_d    = StFetch;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          if (upd_valid) retire = 1'b1;
          else           state_d = StExec;
        end
      end
      StExec: begin
        if (upd_valid) retire = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    if (retire) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // A trapped unit stays parked in EXEC until reset.
      if (fault_q || next_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = StExec;
      end else begin
        pc_d      = next_pc;
        instret_d = instret_q + 32'd1;
        state_d   = StFetch;
      end
`else
      pc_d      = next_pc & ~32'h3;
      instret_d = instret_q + 32'd1;
      state_d   = StFetch;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      instr_q    <= Nop;
      instr_pc_q <= RESET_PC;
      instret_q  <= 32'd0;
      wait_cnt_q <= 8'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      instret_q  <= instret_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch/issue/retire protocol.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int          WaitMax = 255;
  localparam logic [1:0]  Pc4     = 2'b00;
  localparam logic [1:0]  PcBeq   = 2'b01;
  localparam logic [1:0]  PcImm   = 2'b10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instruction, instr_pc;
  logic        upd_valid = 1'b0;
  logic [1:0]  orig_pc = Pc4;
  logic        branch_taken = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] instret;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .upd_valid      (upd_valid),
    .orig_pc        (orig_pc),
    .branch_taken   (branch_taken),
    .imm            (imm),
    .instret        (instret),
    .fetch_fault    (fetch_fault)
  );

  // Transaction-level model: which phase of the one in-flight instruction we are in.
  bit          m_live = 0;
  bit          m_waiting, m_have, m_exec, m_fault;
  int          m_wcnt;
  logic [31:0] m_pc, m_instr, m_ipc, m_instret;

  task automatic m_retire();
    logic [31:0] nxt;
    nxt = m_pc + ((orig_pc == PcImm || (orig_pc == PcBeq && branch_taken)) ? imm : 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (m_fault || nxt[1:0] != 2'b00) begin
      m_fault = 1;
      m_exec  = 1;
    end else begin
      m_pc      = nxt;
      m_instret = m_instret + 32'd1;
      m_exec    = 0;
    end
`else
    m_pc      = nxt & ~32'h3;
    m_instret = m_instret + 32'd1;
    m_exec    = 0;
`endif
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_live = 1; m_waiting = 0; m_have = 0; m_exec = 0; m_fault = 0; m_wcnt = 0;
      m_pc = ResetPc; m_instr = 32'h0000_0013; m_ipc = ResetPc; m_instret = '0;
    end else if (m_live) begin
      if (m_waiting) begin
        if (imem_resp_valid) begin
          m_waiting = 0; m_have = 1; m_instr = imem_resp_data; m_ipc = m_pc;
        end else begin
          m_wcnt++;
          if (m_wcnt == WaitMax) m_waiting = 0;
        end
      end else if (m_have) begin
        if (instr_ready) begin
          m_have = 0;
          if (upd_valid) m_retire();
          else           m_exec = 1;
        end
      end else if (m_exec) begin
        if (upd_valid) m_retire();
      end else if (imem_req_ready) begin
        m_waiting = 1; m_wcnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    bit exp_req;
    forever begin
      @(negedge clock);
      if (m_live) begin
        exp_req = !(m_waiting || m_have || m_exec);
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_have));
        check("instruction", instruction, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        check("instret", instret, m_instret);
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1; imem_resp_valid = 1; imem_resp_data = 32'hDEAD_BEEF;
    imem_req_ready = 1; upd_valid = 1; instr_ready = 1;
    repeat (2) @(negedge clock);
    reset = 0; imem_resp_valid = 0; imem_req_ready = 0; upd_valid = 0; instr_ready = 0;
  endtask

  // Tasks start and end on a negedge; "now" is the cycle whose inputs are being set.
  task automatic fetch_word(input logic [31:0] w);
    imem_req_ready = 1;
    @(negedge clock);
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = w;
    @(negedge clock);
    imem_resp_valid = 0; imem_resp_data = '0;
  endtask

  task automatic accept_retire(input logic [1:0] o, input logic t, input logic [31:0] im,
                               input bit same);
    instr_ready = 1; orig_pc = o; branch_taken = t; imm = im; upd_valid = same;
    @(negedge clock);
    instr_ready = 0;
    if (same) upd_valid = 0;
    else begin
      upd_valid = 1;
      @(negedge clock);
      upd_valid = 0;
    end
  endtask

  task automatic step(input logic [1:0] o, input logic t, input logic [31:0] im);
    fetch_word($urandom);
    accept_retire(o, t, im, 0);
  endtask

  initial begin
    int n;
    bit armed;
    int left;
    logic [31:0] r_imm;
    fork
      compare_loop();
    join_none

    // Reset state, with junk on every input during reset.
    do_reset();
    imem_resp_valid = 1; imem_resp_data = 32'hBAD0_BAD0;
    check("rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", instruction, 32'h0000_0013);
    check("rst_instret", instret, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    @(negedge clock);
    imem_resp_valid = 0;
    check("stale_ignored_valid", 32'(instr_valid), 32'd0);
    check("stale_ignored_req", 32'(imem_req_valid), 32'd1);

    fetch_word(32'h0050_0093);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_instr", instruction, 32'h0050_0093);
    check("first_pc", instr_pc, 32'h0);
    repeat (5) begin
      @(negedge clock);
      check("hold_instr", instruction, 32'h0050_0093);
      check("hold_no_req", 32'(imem_req_valid), 32'd0);
    end
    accept_retire(Pc4, 0, 32'h0, 1);
    check("pc4_addr", imem_addr, 32'h4);
    check("pc4_instret", instret, 32'd1);

    repeat (3) step(Pc4, 0, 32'h0);
    check("addr_0x10", imem_addr, 32'h10);
    step(PcBeq, 1, 32'hFFFF_FFF8);
    check("beq_taken", imem_addr, 32'h08);
    repeat (2) step(Pc4, 0, 32'h0);
    step(PcBeq, 0, 32'hFFFF_FFF8);
    check("beq_not_taken", imem_addr, 32'h14);
    step(PcImm, 0, 32'hFFFF_FFE8);
    check("addr_top", imem_addr, 32'hFFFF_FFFC);
    step(Pc4, 0, 32'h0);
    check("pc_wrap", imem_addr, 32'h0);
    check("instret_10", instret, 32'd10);
    step(PcImm, 0, 32'h100);
    step(PcImm, 0, 32'h20);
    check("pcimm_0x120", imem_addr, 32'h120);

    // Request accepted, response never comes.
    imem_req_ready = 1;
    @(negedge clock);
    imem_req_ready = 0;
    n = 0;
    while (!imem_req_valid && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check("timeout_cycles", 32'(n), 32'(WaitMax));
    check("retry_addr", imem_addr, 32'h120);

    step(PcImm, 0, 32'h2);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_fault", 32'(fetch_fault), 32'd1);
    repeat (10) begin
      upd_valid = 1; orig_pc = Pc4; imem_req_ready = 1;
      @(negedge clock);
      check("trap_parked", 32'(imem_req_valid), 32'd0);
    end
    upd_valid = 0; imem_req_ready = 0;
    check("trap_instret", instret, 32'd12);
`else
    check("mask_addr", imem_addr, 32'h120);
    check("mask_fault", 32'(fetch_fault), 32'd0);
    check("mask_instret", instret, 32'd13);
`endif

    // Randomized traffic; model checks every cycle.
    do_reset();
    armed = 0; left = 0;
    repeat (20000) begin
      @(negedge clock);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      if (m_waiting) begin
        if (!armed) begin
          armed = 1;
          left  = ($urandom_range(0, 99) < 3) ? -1 : int'($urandom_range(0, 3));
        end
        if (left == 0) begin
          imem_resp_valid = 1; imem_resp_data = $urandom;
        end else begin
          imem_resp_valid = 0;
          if (left > 0) left--;
        end
      end else begin
        armed = 0;
        imem_resp_valid = ($urandom_range(0, 99) < 15);
        imem_resp_data  = $urandom;
      end
      instr_ready  = 1'($urandom_range(0, 1));
      upd_valid    = (m_have && !instr_ready) ? 1'b0 : ($urandom_range(0, 9) < 4);
      orig_pc      = 2'($urandom_range(0, 3));
      branch_taken = 1'($urandom_range(0, 1));
      r_imm = 32'((int'($urandom_range(0, 64)) - 32) * 4);
      if ($urandom_range(0, 19) == 0) r_imm = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_imm = r_imm & ~32'h3;
`endif
      imm = r_imm;
    end
    @(negedge clock);
    imem_req_ready = 0; imem_resp_valid = 0; instr_ready = 0; upd_valid = 0;
    check("rand_progress", 32'(m_instret > 32'd200), 32'd1);
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
